// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add multiplier (N x N -> 2N) that borrows an external
// N-bit adder. Signed operands are reduced to magnitudes first. After the N
// shift-add steps, the product is conditionally negated.
//
// Optional feature: define MUL_SEQ_OVF_FLAG_EN to add the ovf output. ovf is set
// when the product does not fit in N bits (signed or unsigned, as appropriate).
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, signed_op    request a multiply (accepted in IDLE/DONE), signedness
//   a, b                multiplicand / multiplier, sampled with start
//   busy, done          operation in flight / one-cycle completion pulse
//   hi, lo              upper / lower half of the 2N-bit product
//   add_a, add_b, add_cin   operands driven to the external adder
//   add_sum, add_c      combinational sum / carry-out from the external adder
//   ovf                 (MUL_SEQ_OVF_FLAG_EN only) result does not fit in N bits
// N must be at least 2.
module mul_seq #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         signed_op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_c
`ifdef MUL_SEQ_OVF_FLAG_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  typedef enum logic [2:0] {
    StIdle, StAbsA, StAbsB, StMul, StNegLo, StNegHi, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  ma_q, ma_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sres_q, sres_d;   // final product must be negated
  logic          sop_q, sop_d;     // operation was signed
  logic          ncarry_q, ncarry_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef MUL_SEQ_OVF_FLAG_EN
  logic          ovf_q, ovf_d;
`endif

  // Adder operand steering; zero in IDLE and DONE.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      StAbsA: begin
        add_a   = ~ma_q;
        add_cin = 1'b1;
      end
      StAbsB: begin
        add_a   = ~lo_q;
        add_cin = 1'b1;
      end
      StMul: begin
        add_a = hi_q;
        add_b = lo_q[0] ? ma_q : '0;
      end
      StNegLo: begin
        add_a   = ~lo_q;
        add_cin = 1'b1;
      end
      StNegHi: begin
        add_a   = ~hi_q;
        add_cin = ncarry_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ma_d     = ma_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    sres_d   = sres_q;
    sop_d    = sop_q;
    ncarry_d = ncarry_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          ma_d    = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          sres_d  = signed_op & (a[N-1] ^ b[N-1]);
          sop_d   = signed_op;
          state_d = signed_op ? StAbsA : StMul;
        end
      end
      StAbsA: begin
        // The most negative value negates to itself, which is its correct
        // unsigned magnitude.
        if (ma_q[N-1]) ma_d = add_sum;
        state_d = StAbsB;
      end
      StAbsB: begin
        if (lo_q[N-1]) lo_d = add_sum;
        state_d = StMul;
      end
      StMul: begin
        // Multiplier bits shift out of lo while product bits shift in from hi.
        hi_d  = {add_c, add_sum[N-1:1]};
        lo_d  = {add_sum[0], lo_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastCnt) state_d = sop_q ? StNegLo : StDone;
      end
      StNegLo: begin
        if (sres_q) lo_d = add_sum;
        ncarry_d = add_c;
        state_d  = StNegHi;
      end
      StNegHi: begin
        if (sres_q) hi_d = add_sum;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d = !(state_d inside {StIdle, StDone});
  assign done_d = (state_d == StDone);

`ifdef MUL_SEQ_OVF_FLAG_EN
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == StIdle || state_q == StDone) && start) begin
      ovf_d = 1'b0;
    end else if (state_d == StDone) begin
      ovf_d = sop_q ? (hi_d != {N{lo_d[N-1]}}) : (hi_d != '0);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      ma_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      sres_q   <= 1'b0;
      sop_q    <= 1'b0;
      ncarry_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MUL_SEQ_OVF_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ma_q     <= ma_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      sres_q   <= sres_d;
      sop_q    <= sop_d;
      ncarry_q <= ncarry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MUL_SEQ_OVF_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MUL_SEQ_OVF_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_mul_seq.sv
// Testbench for mul_seq (N=32). It models the external adder, keeps a scoreboard
// of expected results, and drives a vector table, random vectors and corner sequences.
module tb_mul_seq;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done;
  logic [N-1:0] hi, lo, add_a, add_b, add_sum;
  logic         add_cin, add_c;
  logic [N:0]   sum_full;
`ifdef MUL_SEQ_OVF_FLAG_EN
  logic         ovf;
`endif

  mul_seq #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .signed_op(signed_op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_sum (add_sum),
    .add_c   (add_c)
`ifdef MUL_SEQ_OVF_FLAG_EN
    ,
    .ovf     (ovf)
`endif
  );

  // External adder
  assign sum_full = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
  assign add_sum  = sum_full[N-1:0];
  assign add_c    = sum_full[N];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  typedef struct {
    int          t0;
    int          lat;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        eovf;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        sop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        eovf;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (reset_n && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, e.ehi});
        chk("lo", {32'b0, lo}, {32'b0, e.elo});
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
`ifdef MUL_SEQ_OVF_FLAG_EN
        chk("ovf", {63'b0, ovf}, {63'b0, e.eovf});
`endif
      end
    end
  end

  // Drive start for one cycle; returns at the negedge of cycle 1.
  task automatic launch(input logic sop, input logic [31:0] va, input logic [31:0] vb,
                        input logic expect_it, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic eovf);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    signed_op = sop;
    a = va;
    b = vb;
    if (expect_it) begin
      e.t0 = cyc;
      e.lat = sop ? N + 5 : N + 1;
      e.ehi = ehi;
      e.elo = elo;
      e.eovf = eovf;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = '0;
    b = '0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 120) begin
      @(negedge clk);
      n++;
    end
    chk("completion_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
  endtask

  function automatic vec_t model(input logic sop, input logic [31:0] va, input logic [31:0] vb);
    vec_t v;
    logic signed [63:0] sa, sb2, sp;
    logic [63:0] p;
    if (sop) begin
      sa = {{32{va[31]}}, va};
      sb2 = {{32{vb[31]}}, vb};
      sp = sa * sb2;
      p = sp;
    end else begin
      p = {32'b0, va} * {32'b0, vb};
    end
    v.sop = sop;
    v.a = va;
    v.b = vb;
    v.ehi = p[63:32];
    v.elo = p[31:0];
    v.eovf = sop ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'd0);
    return v;
  endfunction

  initial begin
    int d0;
    // Directed table: {signed, a, b, hi, lo, ovf}
    vecs.push_back('{1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1});
    vecs.push_back('{1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b1});
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(model(1'($urandom_range(0, 1)), $urandom, $urandom));
    end

    // Reset state
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    chk("rst_add_a", {32'b0, add_a}, 64'd0);
    chk("rst_add_cin", {63'b0, add_cin}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Busy/done profile of an unsigned op (3*5)
    launch(1'b0, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      chk($sformatf("busy_c%0d", k), {62'b0, busy, done}, 64'b10);
      @(negedge clk);
    end
    chk("done_c33", {62'b0, busy, done}, 64'b01);
    chk("idle_add_b", {32'b0, add_b}, 64'd0);
    @(negedge clk);
    chk("done_pulse_c34", {62'b0, busy, done}, 64'b00);
    chk("hold_lo", {32'b0, lo}, 64'd15);
    wait_empty();

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      launch(vecs[i].sop, vecs[i].a, vecs[i].b, 1'b1, vecs[i].ehi, vecs[i].elo, vecs[i].eovf);
      wait_empty();
    end

    // Ignored start while busy, then back-to-back start in DONE
    launch(1'b0, 32'd7, 32'd9, 1'b1, 32'd0, 32'd63, 1'b0);
    repeat (9) @(negedge clk);
    start = 1'b1;
    a = 32'd1;
    b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    chk("b2b_done_c33", {63'b0, done}, 64'd1);
    begin
      exp_t e;
      start = 1'b1;
      signed_op = 1'b0;
      a = 32'd2;
      b = 32'd2;
      e.t0 = cyc;
      e.lat = N + 1;
      e.ehi = 32'd0;
      e.elo = 32'd4;
      e.eovf = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    // Reset mid-operation
    launch(1'b1, 32'hFFFF_FFFB, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_hi", {32'b0, hi}, 64'd0);
    chk("abort_lo", {32'b0, lo}, 64'd0);
    d0 = done_cnt;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    launch(1'b0, 32'd4, 32'd4, 1'b1, 32'd0, 32'd16, 1'b0);
    wait_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
